regfile_read_arbiter: RTL

- Shares the register file's two combinational read ports (sel1/sel2 → rs1/rs2, 32 x 32-bit, x0 hard-wired zero) between NUM_REQ requesters, e.g. pipeline decode (req 0) and debug unit (req 1).
- Round-robin arbitration; valid/ready request handshake; registered response with 1-cycle latency and backpressure.
- Sits between the requesters and the register-read mux; drives its select lines and captures its data outputs.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/regfile_read_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the read-arbiter response-slot state type.
package regfile_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREGS = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rd_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IW'((32'(ptr_i) + k) % NUM_REQ);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of the register-file read ports with a one-entry response slot.
// Define REGFILE_READ_ARBITER_BYPASS_EN to forward same-cycle write-back data.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 5,
  localparam int unsigned IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_rs1,
  input  logic [NUM_REQ*AW-1:0] req_rs2,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [AW-1:0]         sel1,
  output logic [AW-1:0]         sel2,
  input  logic [XLEN-1:0]       rf_rs1,
  input  logic [XLEN-1:0]       rf_rs2,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output logic [XLEN-1:0]       rsp_rs1,
  output logic [XLEN-1:0]       rsp_rs2
);

  rd_arb_state_t       state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       rsp_id_q;
  logic [XLEN-1:0]     rsp_rs1_q, rsp_rs2_q;
  logic [XLEN-1:0]     cap_rs1, cap_rs2;
  logic [NUM_REQ-1:0]  gnt;
  logic [IW-1:0]       win_idx;
  logic                slot_free, arb_en, grant;

  assign slot_free = (state_q == EMPTY) || rsp_ready;
  assign arb_en    = slot_free && !rst;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_rr (
    .req_i(req_valid),
    .ptr_i(rr_ptr_q),
    .en_i (arb_en),
    .gnt_o(gnt),
    .idx_o(win_idx)
  );

  assign grant     = |gnt;
  assign req_ready = gnt;

  always_comb begin
    sel1 = '0;
    sel2 = '0;
    if (grant) begin
      sel1 = req_rs1[win_idx*AW +: AW];
      sel2 = req_rs2[win_idx*AW +: AW];
    end
  end

`ifdef REGFILE_READ_ARBITER_BYPASS_EN
  // x0 never takes the bypass, so it still reads as zero from the file.
  always_comb begin
    cap_rs1 = rf_rs1;
    cap_rs2 = rf_rs2;
    if (wb_en && (wb_addr == sel1) && (wb_addr != '0)) cap_rs1 = wb_data;
    if (wb_en && (wb_addr == sel2) && (wb_addr != '0)) cap_rs2 = wb_data;
  end
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr, wb_data};
  assign cap_rs1   = rf_rs1;
  assign cap_rs2   = rf_rs2;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (rsp_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid = (state_q == FULL);
    rsp_id    = rsp_id_q;
    rsp_rs1   = rsp_rs1_q;
    rsp_rs2   = rsp_rs2_q;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      rsp_id_q  <= '0;
      rsp_rs1_q <= '0;
      rsp_rs2_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (grant) begin
        rsp_id_q  <= win_idx;
        rsp_rs1_q <= cap_rs1;
        rsp_rs2_q <= cap_rs2;
      end
    end
  end

endmodule
